simple_logic: RTL and testbench
===============================

// Module: simple_logic
//
// PURPOSE
// - 3-input bitwise AND gate with a combinational output and a registered copy.
// - Optional saturating counter of cycles where the registered result is all-ones.
// - Leaf glue-logic cell for fundamentals-level datapaths.
// - Combinational path feeds local decode; registered path feeds timing-critical consumers.
//
// PARAMETERS
// - WIDTH   1   bit width of a, b, c, result, result_q (bitwise operation)
// - CNT_W   16  width of hit_cnt (used only when SIMPLE_LOGIC_CNT_EN is defined)
//
// PORTS
// - clk       in   1      single clock; all state updates on rising edge
// - rst_n     in   1      asynchronous, active-low reset
// - a         in   WIDTH  operand A
// - b         in   WIDTH  operand B
// - c         in   WIDTH  operand C
// - en        in   1      register-stage update enable
// - result    out  WIDTH  combinational a & b & c
// - result_q  out  WIDTH  registered a & b & c
// - valid_q   out  1      result_q holds a sample captured since reset
// - hit_cnt   out  CNT_W  count of cycles with result_q all-ones (macro only)
//
// BEHAVIOUR
// - result = a & b & c, bitwise and purely combinational.
//   - Zero clock latency; settles within the same delta as the inputs.
//   - Independent of clk, en and rst_n.
// - Truth table per bit, abc -> result:
//   - 000,100,010,110,001,101,011 -> 0
//   - 111 -> 1
// - Reset (rst_n=0), asynchronous assert, takes effect immediately regardless of clk:
//   - result_q = 0, valid_q = 0, hit_cnt = 0
// - Reset release is synchronous to clk.
//   - First capture can occur on the first rising edge with rst_n=1.
// - Rising edge with en=1: result_q <= a & b & c; valid_q <= 1.
//   - Latency is 1 cycle from inputs to result_q.
// - Rising edge with en=0: result_q and valid_q hold.
// - valid_q stays 1 until the next reset; it is never cleared by en=0.
// - Reset mid-operation: all state clears at once.
//   - The next en=1 edge after release recaptures.
// - X/Z on inputs propagates per standard 4-state AND semantics. No masking.
//
// CONFIGURATION
// - SIMPLE_LOGIC_CNT_EN defined:
//   - On each rising edge where valid_q=1 and result_q is all-ones, hit_cnt increments by 1.
//   - hit_cnt saturates at 2**CNT_W-1; it does not wrap.
//   - Increment is evaluated on the pre-edge result_q, so it lags result_q by one cycle.
//   - A simultaneous capture of a new value does not affect that edge's increment.
// - SIMPLE_LOGIC_CNT_EN undefined:
//   - hit_cnt port is still present, tied to 0.
//   - No counter flops are synthesized.
//
// TESTING
// - Exhaustive sweep of abc over all 8 combos, 10 ns apart, WIDTH=1 -> result=1 only for 111, else 0.
// - rst_n=0 mid-cycle while result_q=1 -> result_q=0 and valid_q=0 immediately, before the next edge.
// - a=b=c=1 with en=1 for 1 edge, then a=0 with en=0 for 3 edges -> result=0, result_q stays 1.
// - WIDTH=4: a=4'b1111, b=4'b1010, c=4'b0110 -> result=4'b0010; result_q=4'b0010 one edge later.
// - CNT_EN with CNT_W=2, a=b=c=1, en=1 for 6 edges -> hit_cnt 0,0,1,2,3,3 (saturates).
// - Without the macro, same stimulus -> hit_cnt=0 throughout.

Source files
------------

// File: rtl/simple_logic.sv
// simple_logic: 3-input bitwise AND with a combinational output, a registered
// copy with a sticky valid flag, and an optional saturating hit counter.
// Optional feature macro: SIMPLE_LOGIC_CNT_EN (enables the hit_cnt counter;
// when undefined hit_cnt is tied to zero and no counter flops exist).
module simple_logic #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic             en,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_q,
    output logic             valid_q,
    output logic [CNT_W-1:0] hit_cnt
);

    logic [WIDTH-1:0] result_d;
    logic             valid_d;

    // Combinational AND; 4-state semantics pass X/Z through unmasked.
    assign result = a & b & c;

    // Next-state for the capture stage: load on en, otherwise hold.
    always_comb begin
        result_d = result_q;
        valid_d  = valid_q;
        if (en) begin
            result_d = result;
            valid_d  = 1'b1;
        end
    end

    // Capture register; valid stays set until the next reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

`ifdef SIMPLE_LOGIC_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] hit_cnt_q;
    logic [CNT_W-1:0] hit_cnt_d;

    // Count on the pre-edge registered value so a same-edge capture is ignored.
    always_comb begin
        hit_cnt_d = hit_cnt_q;
        if (valid_q && (result_q == {WIDTH{1'b1}}) && (hit_cnt_q != CNT_MAX)) begin
            hit_cnt_d = hit_cnt_q + CNT_W'(1);
        end
    end

    // Saturating hit counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q <= '0;
        end else begin
            hit_cnt_q <= hit_cnt_d;
        end
    end

    assign hit_cnt = hit_cnt_q;
`else
    assign hit_cnt = '0;
`endif

endmodule

// File: tb/tb_simple_logic.sv
// Self-checking bench for simple_logic (WIDTH=4, CNT_W=2) with a behavioural
// model of the capture register, valid flag and saturating hit counter.
module tb_simple_logic;

    localparam int unsigned W  = 4;
    localparam int unsigned CW = 2;
    localparam int          CNT_MAX = (1 << CW) - 1;
`ifdef SIMPLE_LOGIC_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic [W-1:0]  a, b, c;
    logic          en;
    logic [W-1:0]  result;
    logic [W-1:0]  result_q;
    logic          valid_q;
    logic [CW-1:0] hit_cnt;

    // Behavioural model state
    logic [W-1:0]  m_rq;
    bit            m_vq;
    int            m_cnt;

    int n_checks;
    int n_fail;

    simple_logic #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a),
        .b        (b),
        .c        (c),
        .en       (en),
        .result   (result),
        .result_q (result_q),
        .valid_q  (valid_q),
        .hit_cnt  (hit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model update for one rising edge, evaluated from pre-edge state.
    task automatic model_edge();
        if (rst_n) begin
            if (CNT_EN && m_vq && (m_rq == {W{1'b1}}) && (m_cnt < CNT_MAX))
                m_cnt++;
            if (en) begin
                m_rq = a & b & c;
                m_vq = 1'b1;
            end
        end
    endtask

    task automatic model_reset();
        m_rq  = '0;
        m_vq  = 1'b0;
        m_cnt = 0;
    endtask

    // Drive inputs, advance through one rising edge, leave time at edge+2.
    task automatic cycle(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic [W-1:0] ic, input logic ien);
        a  = ia;
        b  = ib;
        c  = ic;
        en = ien;
        @(posedge clk);
        model_edge();
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Compare process: checks all outputs against the model every falling edge.
    always @(negedge clk) begin
        chk("result",   32'(result),   32'(a & b & c));
        chk("result_q", 32'(result_q), 32'(m_rq));
        chk("valid_q",  32'(valid_q),  32'(m_vq));
        chk("hit_cnt",  32'(hit_cnt),  32'(m_cnt));
    end

    initial begin
        int exp_pre [6];
        logic [2:0] abc;
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        a = '0; b = '0; c = '0; en = 1'b0;
        model_reset();
        #1;
        chk("reset_result_q", 32'(result_q), 32'h0);
        chk("reset_valid_q",  32'(valid_q),  32'h0);
        chk("reset_hit_cnt",  32'(hit_cnt),  32'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Exhaustive truth table, each bit of the vector driven identically.
        for (int i = 0; i < 8; i++) begin
            abc = 3'(i);
            a = {W{abc[2]}};
            b = {W{abc[1]}};
            c = {W{abc[0]}};
            en = 1'b1;
            #1;
            chk("sweep_result", 32'(result), (i == 7) ? 32'hF : 32'h0);
            @(posedge clk);
            model_edge();
            #2;
        end

        // Multi-bit example, combinational now and registered one edge later.
        a = 4'b1111; b = 4'b1010; c = 4'b0110; en = 1'b1;
        #1;
        chk("w4_result", 32'(result), 32'h2);
        @(posedge clk);
        model_edge();
        #2;
        chk("w4_result_q", 32'(result_q), 32'h2);

        // Capture all-ones, then hold for three en=0 edges with a=0.
        cycle(4'hF, 4'hF, 4'hF, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(4'h0, 4'hF, 4'hF, 1'b0);
            chk("hold_result",   32'(result),   32'h0);
            chk("hold_result_q", 32'(result_q), 32'hF);
            chk("hold_valid_q",  32'(valid_q),  32'h1);
        end

        // Asynchronous reset mid-cycle clears state before the next edge.
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_result_q", 32'(result_q), 32'h0);
        chk("async_rst_valid_q",  32'(valid_q),  32'h0);
        chk("async_rst_hit_cnt",  32'(hit_cnt),  32'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Saturating counter: value seen just before each of six all-ones edges.
        exp_pre = CNT_EN ? '{0, 0, 1, 2, 3, 3} : '{0, 0, 0, 0, 0, 0};
        for (int k = 0; k < 6; k++) begin
            a = 4'hF; b = 4'hF; c = 4'hF; en = 1'b1;
            #1;
            chk("cnt_seq", 32'(hit_cnt), 32'(exp_pre[k]));
            @(posedge clk);
            model_edge();
            #2;
        end

        // Randomized phase, biased toward ones, with occasional resets.
        for (int i = 0; i < 400; i++) begin
            logic [W-1:0] ra, rb, rc;
            ra = W'($urandom) | W'($urandom);
            rb = W'($urandom) | W'($urandom);
            rc = W'($urandom) | W'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                ra = '1; rb = '1; rc = '1;
            end
            if ($urandom_range(0, 59) == 0)
                do_reset();
            else
                cycle(ra, rb, rc, 1'($urandom_range(0, 1)));
        end

        @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
